// File: rtl/keypad_pkg.sv
// Shared key-matrix constants, function-key codes, scanner state enum and code helpers.
// Used by the keypad scanner and anything that decodes its 5-bit key codes.
package keypad_pkg;

   localparam int KEY_W = 5;
   localparam int ROWS  = 4;
   localparam int COLS  = 5;

   localparam logic [KEY_W-1:0] KEY_F0 = 5'h10;
   localparam logic [KEY_W-1:0] KEY_F1 = 5'h11;
   localparam logic [KEY_W-1:0] KEY_F2 = 5'h12;
   localparam logic [KEY_W-1:0] KEY_F3 = 5'h13;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } scan_state_t;

   // Columns are active low; the lowest-index low column wins.
   function automatic logic [2:0] lowest_low(input logic [COLS-1:0] cols);
      lowest_low = 3'd0;
      for (int i = COLS-1; i >= 0; i--) begin
         if (!cols[i]) lowest_low = 3'(i);
      end
   endfunction

   function automatic logic [KEY_W-1:0] key_code(input logic [1:0] r, input logic [2:0] c);
      key_code = KEY_W'(r) * KEY_W'(COLS) + KEY_W'(c);
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: tick is high for one clk cycle every CLK_DIV cycles (on the wrap).
// No backpressure; also drives display refresh timing.
module scan_tick_gen #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/keypad_scan_enc.sv
// 4x5 keypad scanner/debouncer: one 5-bit code per press, D_ready high one clk after the qualifying tick.
// Consumer acks with readn low; an unacked code is overwritten by the next one and flags sticky overrun.
module keypad_scan_enc
   import keypad_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [ROWS-1:0]  row_o,
   input  logic [COLS-1:0]  col_i,
   input  logic             readn,
   output logic [KEY_W-1:0] Din,
   output logic             D_ready,
   output logic             overrun
);

   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

   logic [COLS-1:0]  col_meta;
   logic [COLS-1:0]  col_sync;
   logic             tick;
   scan_state_t      state;
   logic [1:0]       row_idx;
   logic [1:0]       key_r;
   logic [2:0]       key_c;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             any_low;
   logic             key_low;
   logic             emit;
   logic [KEY_W-1:0] emit_code;

   scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Columns idle high (external pull-ups), so the synchroniser resets to all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta <= '1;
         col_sync <= '1;
      end else begin
         col_meta <= col_i;
         col_sync <= col_meta;
      end
   end

   assign cnt_inc = cnt + 1'b1;
   assign any_low = ~&col_sync;
   assign key_low = ~col_sync[key_c];

   always_comb begin
      emit      = 1'b0;
      emit_code = key_code(key_r, key_c);
      if (state == SCAN) emit_code = key_code(row_idx, lowest_low(col_sync));
      if (tick) begin
         case (state)
            SCAN:     emit = any_low && (DEBOUNCE_CNT == 1);
            PRESS_DB: emit = key_low && (cnt_inc == CNT_DONE);
            default:  emit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= SCAN;
         row_idx <= 2'd0;
         row_o   <= 4'b1110;
         key_r   <= 2'd0;
         key_c   <= 3'd0;
         cnt     <= '0;
         Din     <= '0;
         D_ready <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (tick) begin
            case (state)
               SCAN: begin
                  if (any_low) begin
                     key_r <= row_idx;
                     key_c <= lowest_low(col_sync);
                     if (DEBOUNCE_CNT == 1) begin
                        cnt   <= '0;
                        state <= HELD;
                     end else begin
                        cnt   <= CNT_W'(1);
                        state <= PRESS_DB;
                     end
                  end else begin
                     row_idx <= row_idx + 2'd1;
                     row_o   <= {row_o[ROWS-2:0], row_o[ROWS-1]};
                  end
               end
               PRESS_DB: begin
                  if (key_low) begin
                     cnt <= cnt_inc;
                     if (cnt_inc == CNT_DONE) begin
                        cnt   <= '0;
                        state <= HELD;
                     end
                  end else begin
                     // Bounce: resume rotation past the row that produced it.
                     cnt     <= '0;
                     state   <= SCAN;
                     row_idx <= key_r + 2'd1;
                     row_o   <= ~(ROWS'(1) << (key_r + 2'd1));
                  end
               end
               HELD: begin
                  if (!key_low) begin
                     if (DEBOUNCE_CNT == 1) begin
                        state <= SCAN;
                     end else begin
                        cnt   <= CNT_W'(1);
                        state <= REL_DB;
                     end
                  end
               end
               REL_DB: begin
                  if (!key_low) begin
                     cnt <= cnt_inc;
                     if (cnt_inc == CNT_DONE) begin
                        cnt   <= '0;
                        state <= SCAN;
                     end
                  end else begin
                     cnt   <= '0;
                     state <= HELD;
                  end
               end
               default: state <= SCAN;
            endcase
         end

         // A fresh code beats a same-cycle ack; an ack in that cycle means nothing was lost.
         if (emit) begin
            Din     <= emit_code;
            D_ready <= 1'b1;
            if (D_ready && readn) overrun <= 1'b1;
         end else if (!readn) begin
            D_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_enc.sv
// Bench for keypad_scan_enc with a behavioural key matrix and a press-list scoreboard.
module tb_keypad_scan_enc;

   localparam int CLK_DIV = 4;
   localparam int DB      = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row_o;
   logic [4:0] col_i;
   logic       readn;
   logic [4:0] Din;
   logic       D_ready;
   logic       overrun;

   logic [19:0] key_down;
   int          checks = 0;
   int          errors = 0;
   int          rises  = 0;
   logic        dr_q   = 1'b0;
   bit          auto_ack = 1'b0;
   logic [4:0]  rx_q[$];
   logic [4:0]  exp_q[$];

   always #5 clk = ~clk;

   keypad_scan_enc #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CNT(DB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .row_o   (row_o),
      .col_i   (col_i),
      .readn   (readn),
      .Din     (Din),
      .D_ready (D_ready),
      .overrun (overrun)
   );

   // Physical matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col_i = 5'h1F;
      for (int r = 0; r < 4; r++)
         if (!row_o[r])
            for (int c = 0; c < 5; c++)
               if (key_down[r*5+c]) col_i[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (D_ready && !dr_q) rises <= rises + 1;
      dr_q <= D_ready;
   end

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (auto_ack) begin
            if (D_ready && readn) begin
               rx_q.push_back(Din);
               readn = 1'b0;
            end else begin
               readn = 1'b1;
            end
         end
      end
   endtask

   // Press right after the scanner starts driving row r, so tick timing is known.
   task automatic press_aligned(input int r, input logic [4:0] cmask);
      logic [3:0] tgt, prev;
      bit done;
      tgt  = ~(4'b0001 << r);
      prev = row_o;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         run_cycles(1);
         if (row_o == tgt && prev != tgt) done = 1'b1;
         prev = row_o;
      end
      checks++;
      if (done) key_down[r*5 +: 5] = cmask;
      else begin errors++; $display("FAIL align_row%0d: row_o=%b never became %b", r, row_o, tgt); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; readn = 1'b1; key_down = '0; auto_ack = 1'b0;
      run_cycles(3);
      checks++; if (row_o !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", row_o); end
      checks++; if (Din !== 5'h00) begin errors++; $display("FAIL reset_din: got %h want 00", Din); end
      checks++; if (D_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", D_ready); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
      @(negedge clk); rst_n = 1'b1;
      run_cycles(2);
   endtask

   task automatic test_single_press();
      int r0;
      bit moved, onehot;
      r0 = rises;
      press_aligned(1, 5'b00100);
      run_cycles(11);
      checks++; if (D_ready !== 1'b0) begin errors++; $display("FAIL single_early: D_ready=%b want 0", D_ready); end
      run_cycles(1);
      checks++; if (D_ready !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", D_ready); end
      checks++; if (Din !== 5'h07) begin errors++; $display("FAIL single_din: got %h want 07", Din); end
      run_cycles(20*CLK_DIV - 12);
      key_down = '0;
      run_cycles(6*CLK_DIV);
      checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL single_once: emits=%0d want 1", rises - r0); end
      moved = 1'b0; onehot = 1'b1;
      for (int i = 0; i < 8*CLK_DIV; i++) begin
         if (row_o != 4'b1101) moved = 1'b1;
         if ($countones(~row_o) != 1) onehot = 1'b0;
         run_cycles(1);
      end
      checks++; if (!moved) begin errors++; $display("FAIL single_rescan: row_o=%b stuck, want rotation", row_o); end
      checks++; if (!onehot) begin errors++; $display("FAIL row_onehot: row_o=%b want one low bit", row_o); end
   endtask

   task automatic test_bounce();
      int r0;
      readn = 1'b0; run_cycles(1); readn = 1'b1;
      r0 = rises;
      press_aligned(1, 5'b00100);
      run_cycles(2*CLK_DIV);
      key_down = '0;
      run_cycles(6*CLK_DIV);
      checks++; if (D_ready !== 1'b0 || rises != r0) begin errors++; $display("FAIL bounce_none: D_ready=%b emits=%0d want 0/0", D_ready, rises - r0); end
      press_aligned(1, 5'b00100);
      run_cycles(3*CLK_DIV);
      checks++; if (D_ready !== 1'b1 || Din !== 5'h07) begin errors++; $display("FAIL bounce_emit: rdy=%b din=%h want 1/07", D_ready, Din); end
      key_down = '0;
      run_cycles(6*CLK_DIV);
      checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL bounce_once: emits=%0d want 1", rises - r0); end
   endtask

   task automatic test_handshake();
      checks++; if (D_ready !== 1'b1) begin errors++; $display("FAIL hs_pre: D_ready=%b want 1", D_ready); end
      readn = 1'b0; run_cycles(1); readn = 1'b1;
      checks++; if (D_ready !== 1'b0 || Din !== 5'h07) begin errors++; $display("FAIL hs_ack: rdy=%b din=%h want 0/07", D_ready, Din); end
      readn = 1'b0; run_cycles(5); readn = 1'b1; run_cycles(1);
      checks++; if (D_ready !== 1'b0 || Din !== 5'h07 || overrun !== 1'b0) begin errors++; $display("FAIL hs_idle: rdy=%b din=%h ovr=%b want 0/07/0", D_ready, Din, overrun); end
   endtask

   task automatic test_simultaneous();
      press_aligned(0, 5'b00010);
      run_cycles(3*CLK_DIV);
      checks++; if (D_ready !== 1'b1 || Din !== 5'h01) begin errors++; $display("FAIL simul_pre: rdy=%b din=%h want 1/01", D_ready, Din); end
      run_cycles(CLK_DIV); key_down = '0; run_cycles(6*CLK_DIV);
      press_aligned(2, 5'b01010);
      run_cycles(3*CLK_DIV - 1);
      readn = 1'b0; run_cycles(1); readn = 1'b1;
      checks++; if (D_ready !== 1'b1 || Din !== 5'h0B) begin errors++; $display("FAIL simul_emit: rdy=%b din=%h want 1/0b", D_ready, Din); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_ovr: got %b want 0", overrun); end
      key_down = '0; run_cycles(6*CLK_DIV);
      readn = 1'b0; run_cycles(1); readn = 1'b1;
   endtask

   task automatic test_random();
      int r, c;
      rx_q.delete(); exp_q.delete();
      auto_ack = 1'b1;
      for (int n = 0; n < 8; n++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 4);
         run_cycles($urandom_range(0, 7));
         key_down[r*5+c] = 1'b1;
         exp_q.push_back(5'(r*5 + c));
         run_cycles(CLK_DIV * $urandom_range(10, 16));
         key_down = '0;
         run_cycles(CLK_DIV * $urandom_range(8, 12));
      end
      auto_ack = 1'b0; readn = 1'b1;
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d codes want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_code%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rand_ovr: got %b want 0", overrun); end
   endtask

   task automatic test_overrun();
      press_aligned(3, 5'b10000);
      run_cycles(3*CLK_DIV);
      checks++; if (D_ready !== 1'b1 || Din !== 5'h13 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: rdy=%b din=%h ovr=%b want 1/13/0", D_ready, Din, overrun); end
      run_cycles(2*CLK_DIV); key_down = '0; run_cycles(6*CLK_DIV);
      press_aligned(0, 5'b00001);
      run_cycles(3*CLK_DIV);
      checks++; if (D_ready !== 1'b1 || Din !== 5'h00 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_second: rdy=%b din=%h ovr=%b want 1/00/1", D_ready, Din, overrun); end
      key_down = '0; run_cycles(10*CLK_DIV);
      readn = 1'b0; run_cycles(1); readn = 1'b1; run_cycles(4);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_mid_reset();
      press_aligned(1, 5'b00001);
      run_cycles(3*CLK_DIV);
      checks++; if (D_ready !== 1'b1 || Din !== 5'h05) begin errors++; $display("FAIL mrst_pre: rdy=%b din=%h want 1/05", D_ready, Din); end
      @(posedge clk); #3 rst_n = 1'b0; #1;
      checks++; if (row_o !== 4'b1110 || Din !== 5'h00 || D_ready !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mrst_async: row=%b din=%h rdy=%b ovr=%b want 1110/00/0/0", row_o, Din, D_ready, overrun); end
      key_down = '0;
      run_cycles(3);
      @(negedge clk); rst_n = 1'b1;
      run_cycles(10*CLK_DIV);
      checks++; if (D_ready !== 1'b0) begin errors++; $display("FAIL mrst_lost: D_ready=%b want 0", D_ready); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_handshake();
      test_simultaneous();
      test_random();
      test_overrun();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
